// File: rtl/instruction_encode_unit.sv
// Encodes arithmetic requests into 16-bit instruction words and queues them
// in a small FIFO for an instruction-memory writer at sequential addresses.
module instruction_encode_unit #(
    parameter int DEPTH   = 4,
    parameter int IMEM_AW = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       req_valid,
    input  logic [1:0]                 req_op,
    input  logic [12:0]                req_addr,
    output logic                       req_ready,
    input  logic                       flush,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [15:0]                out_instr,
    output logic [IMEM_AW-1:0]         out_waddr,
    output logic                       wrap,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;
    localparam logic [LW-1:0] FULL = LW'(DEPTH);

    logic [15:0]   mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic          push;
    logic          pop;

    // Handshake decode; flush suppresses both sides of the transfer.
    assign req_ready = (level < FULL);
    assign out_valid = (level != '0);
    assign push      = req_valid && req_ready && !flush;
    assign pop       = out_valid && out_ready && !flush;

    // Head word drives the output; zero while the FIFO is empty.
    assign out_instr = out_valid ? mem[rd_ptr] : 16'h0000;

    // Storage array needs no reset; only valid entries are ever exposed.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {req_addr, 1'b0, req_op};
        end
    end

    // Pointer, occupancy, write-address and wrap-pulse state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            level     <= '0;
            out_waddr <= '0;
            wrap      <= 1'b0;
        end else if (flush) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            level     <= '0;
            out_waddr <= '0;
            wrap      <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr    <= rd_ptr + 1'b1;
                out_waddr <= out_waddr + 1'b1;
            end
            wrap <= pop && (out_waddr == '1);
            if (push && !pop) begin
                level <= level + 1'b1;
            end else if (pop && !push) begin
                level <= level - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_instruction_encode_unit.sv
// Scoreboard bench: stimulus queues expected words on acceptance, a
// negedge monitor pops and compares whenever the DUT hands a word over.
module tb_instruction_encode_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic [1:0]  req_op = 2'b00;
    logic [12:0] req_addr = 13'h0;
    logic        req_ready;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_instr;
    logic [7:0]  out_waddr;
    logic        wrap;
    logic [2:0]  level;

    int          nvec = 0;
    int          nbad = 0;
    int          wrap_cnt = 0;
    logic [15:0] q[$];
    logic [15:0] e;
    logic [7:0]  exp_waddr = 8'h00;
    logic        exp_wrap = 1'b0;
    logic        exp_wrap_n;

    instruction_encode_unit #(.DEPTH(4), .IMEM_AW(8)) dut (
        .clk(clk),
        .rst(rst),
        .req_valid(req_valid),
        .req_op(req_op),
        .req_addr(req_addr),
        .req_ready(req_ready),
        .flush(flush),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_instr(out_instr),
        .out_waddr(out_waddr),
        .wrap(wrap),
        .level(level)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nbad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Issue one request, hold until accepted, queue its expected encoding.
    task automatic send(input logic [1:0] op, input logic [12:0] addr);
        int n;
        n = 0;
        req_valid = 1'b1;
        req_op    = op;
        req_addr  = addr;
        forever begin
            @(negedge clk);
            if (req_ready && !flush) begin
                q.push_back({addr, 1'b0, op});
                break;
            end
            n++;
            if (n > 50) begin
                chk("send_timeout", 32'd1, 32'd0);
                break;
            end
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        out_ready = 1'b1;
        forever begin
            @(negedge clk);
            if (!out_valid) break;
            n++;
            if (n > 50) begin
                chk("drain_timeout", 32'd1, 32'd0);
                break;
            end
        end
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    // Monitor: wrap timing, handshake pops against the scoreboard.
    always @(negedge clk) begin
        if (!rst) begin
            chk("wrap", 32'(wrap), 32'(exp_wrap));
            if (wrap) wrap_cnt++;
            exp_wrap_n = 1'b0;
            if (flush) begin
                q.delete();
                exp_waddr = 8'h00;
            end else if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    chk("unexpected_word", 32'(out_instr), 32'hFFFF_FFFF);
                end else begin
                    e = q.pop_front();
                    chk("out_instr", 32'(out_instr), 32'(e));
                    chk("out_waddr", 32'(out_waddr), 32'(exp_waddr));
                end
                if (exp_waddr == 8'hFF) exp_wrap_n = 1'b1;
                exp_waddr = exp_waddr + 8'h01;
            end
            if (!out_valid) chk("idle_instr", 32'(out_instr), 32'h0);
            exp_wrap = exp_wrap_n;
        end
    end

    initial begin
        #2;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_ready", 32'(req_ready), 32'd1);
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_instr", 32'(out_instr), 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Encode example
        send(2'b10, 13'h1ABC);
        chk("enc_valid", 32'(out_valid), 32'd1);
        chk("enc_instr", 32'(out_instr), 32'hD5E2);
        chk("enc_waddr", 32'(out_waddr), 32'd0);
        drain();

        // Full FIFO: fifth request held until one pop
        fork
            begin
                for (int i = 0; i < 5; i++)
                    send(2'(i), 13'(13'h0100 + i));
            end
            begin
                repeat (5) @(posedge clk);
                #1;
                chk("full_level", 32'(level), 32'd4);
                chk("full_ready", 32'(req_ready), 32'd0);
                out_ready = 1'b1;
                @(posedge clk);
                #1;
                out_ready = 1'b0;
            end
        join
        chk("full_refill", 32'(level), 32'd4);
        drain();

        // Simultaneous push/pop at level 2
        send(2'b01, 13'h0AAA);
        send(2'b11, 13'h1555);
        chk("pp_level0", 32'(level), 32'd2);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            send(2'(i), 13'(13'h0F00 + i));
            chk("pp_level", 32'(level), 32'd2);
        end
        out_ready = 1'b0;
        drain();

        // Flush with level 3 and a coincident request
        for (int i = 0; i < 3; i++)
            send(2'b00, 13'(13'h0200 + i));
        chk("fl_pre_level", 32'(level), 32'd3);
        req_valid = 1'b1;
        req_addr  = 13'h1FFF;
        flush     = 1'b1;
        @(posedge clk);
        #1;
        flush     = 1'b0;
        req_valid = 1'b0;
        chk("fl_level", 32'(level), 32'd0);
        chk("fl_valid", 32'(out_valid), 32'd0);
        chk("fl_waddr", 32'(out_waddr), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        chk("fl_no_store", 32'(level), 32'd0);

        // 257-word stream: one wrap, address 0 reused
        wrap_cnt = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 257; i++)
            send(2'(i), 13'(i * 7));
        drain();
        repeat (2) @(posedge clk);
        #1;
        chk("wrap_count", 32'(wrap_cnt), 32'd1);
        chk("wrap_waddr", 32'(out_waddr), 32'd1);

        // Async reset mid-stream at level 2, out_waddr 5
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++)
            send(2'b01, 13'(13'h0300 + i));
        drain();
        send(2'b10, 13'h0400);
        send(2'b11, 13'h0401);
        chk("ar_level", 32'(level), 32'd2);
        chk("ar_waddr", 32'(out_waddr), 32'd5);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("ar_valid", 32'(out_valid), 32'd0);
        chk("ar_level0", 32'(level), 32'd0);
        chk("ar_waddr0", 32'(out_waddr), 32'd0);
        chk("ar_ready", 32'(req_ready), 32'd1);
        q.delete();
        exp_waddr = 8'h00;
        exp_wrap  = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        send(2'b01, 13'h0042);
        chk("ar_first_waddr", 32'(out_waddr), 32'd0);
        chk("ar_first_instr", 32'(out_instr), 32'h0211);
        drain();

        chk("sb_empty", 32'(q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule

// File: doc/instruction_encode_unit.md
INSTRUCTION_ENCODE_UNIT -- requirements
Module: instruction_encode_unit

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, giving the encoded-word FIFO depth (power of 2, >=2).
REQ-002 The block SHALL have parameter IMEM_AW, default 8, giving the instruction-memory write-address width.
REQ-003 The block SHALL have one clock and an asynchronous, active-high reset, named as the codebase does: clk  input  1  rising-edge clock.
REQ-004 rst  input  1  asynchronous active-high reset.
REQ-005 req_valid  input  1  operation request present.
REQ-006 req_op  input  2  opcode: 00 ADD, 01 SUB, 10 MUL, 11 DIV.
REQ-007 req_addr  input  13  data-memory operand address.
REQ-008 req_ready  output  1  block can accept a request this cycle.
REQ-009 flush  input  1  synchronous clear of FIFO and write address.
REQ-010 out_valid  output  1  out_instr/out_waddr hold a valid word.
REQ-011 out_ready  input  1  instruction-memory writer accepts the word.
REQ-012 out_instr  output  16  encoded instruction word.
REQ-013 out_waddr  output  IMEM_AW  instruction-memory address for out_instr.
REQ-014 wrap  output  1  one-cycle pulse when out_waddr wraps.
REQ-015 level  output  $clog2(DEPTH)+1  current FIFO occupancy.

Function
REQ-016 Encoding SHALL be out_instr = {req_addr[12:0], 1'b0, req_op[1:0]}; bit 2 always 0.
REQ-017 A request SHALL be accepted on a rising edge where req_valid && req_ready && !flush.
REQ-018 req_ready SHALL equal (level < DEPTH), combinational from registered state only; no push when full even if a pop occurs the same cycle.
REQ-019 Accepted words SHALL be stored in FIFO order; the head word SHALL drive out_instr.
REQ-020 out_valid SHALL equal (level != 0); latency from accepting edge into empty FIFO to out_valid=1 SHALL be one cycle (visible after that edge).
REQ-021 A word SHALL be popped on a rising edge where out_valid && out_ready && !flush.
REQ-022 out_instr and out_waddr SHALL remain stable while out_valid=1 and out_ready=0.
REQ-023 Simultaneous push and pop (FIFO non-empty, non-full) SHALL leave level unchanged and keep order.
REQ-024 out_waddr SHALL increment by 1 on each pop, modulo 2^IMEM_AW.
REQ-025 wrap SHALL pulse high for the cycle following a pop at out_waddr = 2^IMEM_AW-1; out_waddr then equals 0.
REQ-026 out_ready while out_valid=0 SHALL have no effect; req_valid while req_ready=0 SHALL be ignored (requester holds).
REQ-027 flush=1 SHALL, at the edge, set level=0, read/write pointers=0, out_waddr=0, wrap=0, and discard any coincident push or pop.
REQ-028 Internal read/write pointers SHALL wrap modulo DEPTH.

Reset
REQ-029 rst=1 SHALL immediately, independent of clk, set level=0, pointers=0, out_waddr=0, wrap=0, hence out_valid=0, req_ready=1.
REQ-030 out_instr SHALL read 16'h0000 while out_valid=0 after reset; storage contents need not be cleared.
REQ-031 rst asserted mid-transfer SHALL discard all buffered words; first word after release SHALL go to out_waddr=0.

Verification
REQ-032 Encode: push op=10, addr=13'h1ABC -> next cycle out_valid=1, out_instr=16'hD5E2, out_waddr=0.
REQ-033 Full: out_ready=0, push 5 requests -> first 4 accepted, level=4, req_ready=0, 5th held; then one pop -> 5th accepted next edge, order preserved.
REQ-034 Simultaneous push/pop at level=2 -> level stays 2; output sequence matches input sequence, out_waddr increments by 1.
REQ-035 Wrap: IMEM_AW=8, stream 257 words with out_ready=1 -> wrap pulses once after word at address 255; word 257 at out_waddr=0... i.e. address 0 reused.
REQ-036 Flush with level=3 and req_valid=1 -> next cycle level=0, out_valid=0, out_waddr=0, request not stored.
REQ-037 Async reset mid-stream (level=2, out_waddr=5) between clock edges -> out_valid=0, level=0, out_waddr=0 immediately.
